// File: rtl/ddr_wr_ins_scheduler.sv
// DDR write-instruction scheduler: buffers no-backpressure instructions in a FWFT FIFO,
// issues them over valid/ready, and reports per-layer and network completion once drained.
module ddr_wr_ins_scheduler #(
  parameter int BITWIDTH = 32,
  parameter int INS_W    = BITWIDTH * 16 + 34,
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_TH    = 12
) (
  input  logic             clk_calc,
  input  logic             rst,
  input  logic             ins_in_vld,
  input  logic [INS_W-1:0] ins_in,
  input  logic             last_slice_vld,
  input  logic             net_map_finish,
  output logic             almost_full,
  output logic             ddr_ins_vld,
  output logic [INS_W-1:0] ddr_ins,
  input  logic             ddr_ins_rdy,
  output logic             layer_done,
  output logic [15:0]      layer_ins_cnt,
  output logic             net_done,
  output logic             ovf_err,
  output logic [AW:0]      fifo_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [INS_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             af_q, ovf_q, net_q, net_d;
  logic [15:0]      ins_cnt_q, ins_cnt_d;
  logic             full, push, pop;

  assign full = (cnt_q == (AW+1)'(DEPTH));
  assign pop  = (cnt_q != '0) && ddr_ins_rdy;
  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted.
  assign push = ins_in_vld && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_calc) begin
    if (push) mem_q[wr_ptr_q] <= ins_in;
  end

  always_ff @(posedge clk_calc or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      af_q      <= 1'b0;
      ovf_q     <= 1'b0;
      net_q     <= 1'b0;
      ins_cnt_q <= '0;
      state_q   <= S_IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q     <= cnt_d;
      af_q      <= (cnt_d >= (AW+1)'(AF_TH));
      if (ins_in_vld && full && !pop) ovf_q <= 1'b1;
      net_q     <= net_d;
      ins_cnt_q <= ins_cnt_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ins_cnt_d = ins_cnt_q;
    net_d     = net_q || net_map_finish;
    if (pop && (ins_cnt_q != 16'hFFFF)) ins_cnt_d = ins_cnt_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (last_slice_vld)  state_d = S_DRAIN;
        else if (ins_in_vld) state_d = S_RUN;
      end
      S_RUN: begin
        if (last_slice_vld) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((cnt_q == '0) && !push) state_d = S_DONE;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        ins_cnt_d = '0;
        // A finish arriving during DONE belongs to the following layer.
        net_d     = net_map_finish;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ddr_ins_vld   = (cnt_q != '0);
  assign ddr_ins       = ddr_ins_vld ? mem_q[rd_ptr_q] : '0;
  assign almost_full   = af_q;
  assign ovf_err       = ovf_q;
  assign fifo_cnt      = cnt_q;
  assign layer_done    = (state_q == S_DONE);
  assign layer_ins_cnt = layer_done ? ins_cnt_q : '0;
  assign net_done      = layer_done && net_q;

endmodule

// File: tb/tb_ddr_wr_ins_scheduler.sv
// Self-checking bench for ddr_wr_ins_scheduler: directed scenarios plus random traffic
// compared cycle by cycle against a queue-based reference model.
module tb_ddr_wr_ins_scheduler;
  localparam int BITWIDTH = 32;
  localparam int INS_W    = BITWIDTH * 16 + 34;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int AF_TH    = 12;

  logic             clk_calc = 1'b0;
  logic             rst;
  logic             ins_in_vld, last_slice_vld, net_map_finish, ddr_ins_rdy;
  logic [INS_W-1:0] ins_in;
  logic             almost_full, ddr_ins_vld, layer_done, net_done, ovf_err;
  logic [INS_W-1:0] ddr_ins;
  logic [15:0]      layer_ins_cnt;
  logic [AW:0]      fifo_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_ld     = 0;

  // Reference model state
  logic [INS_W-1:0] mq[$];
  int unsigned      m_ins_cnt;
  bit               m_ovf, m_af, m_ending, m_done, m_net;

  always #5 clk_calc = ~clk_calc;

  ddr_wr_ins_scheduler #(
    .BITWIDTH(BITWIDTH), .INS_W(INS_W), .DEPTH(DEPTH), .AW(AW), .AF_TH(AF_TH)
  ) dut (
    .clk_calc(clk_calc), .rst(rst), .ins_in_vld(ins_in_vld), .ins_in(ins_in),
    .last_slice_vld(last_slice_vld), .net_map_finish(net_map_finish),
    .almost_full(almost_full), .ddr_ins_vld(ddr_ins_vld), .ddr_ins(ddr_ins),
    .ddr_ins_rdy(ddr_ins_rdy), .layer_done(layer_done), .layer_ins_cnt(layer_ins_cnt),
    .net_done(net_done), .ovf_err(ovf_err), .fifo_cnt(fifo_cnt)
  );

  task automatic check(input string tag, input logic [INS_W-1:0] obs, input logic [INS_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [INS_W-1:0] rnd_ins();
    logic [INS_W-1:0] r = '0;
    for (int i = 0; i < (INS_W + 31) / 32; i++) r = {r[INS_W-33:0], $urandom()};
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ins_cnt = 0; m_ovf = 0; m_af = 0; m_ending = 0; m_done = 0; m_net = 0;
  endtask

  // Called at a falling edge: check current outputs, apply inputs, advance model by one clock.
  task automatic step(input bit v, input logic [INS_W-1:0] d, input bit ls, input bit nf, input bit rdy);
    int unsigned sz;
    bit e_vld, pop, push, full, next_done;
    sz    = mq.size();
    e_vld = (sz != 0);
    check("ddr_ins_vld", ddr_ins_vld, e_vld);
    check("ddr_ins", ddr_ins, e_vld ? mq[0] : '0);
    check("fifo_cnt", fifo_cnt, sz);
    check("almost_full", almost_full, m_af);
    check("ovf_err", ovf_err, m_ovf);
    check("layer_done", layer_done, m_done);
    check("layer_ins_cnt", layer_ins_cnt, m_done ? m_ins_cnt : 0);
    check("net_done", net_done, m_done && m_net);
    if (layer_done) n_ld++;

    ins_in_vld = v; ins_in = d; last_slice_vld = ls; net_map_finish = nf; ddr_ins_rdy = rdy;

    pop  = e_vld && rdy;
    full = (sz == DEPTH);
    push = v && (!full || pop);
    if (v && full && !pop) m_ovf = 1;
    next_done = m_ending && (sz == 0) && !push;
    if (ls && !m_ending && !m_done) m_ending = 1;
    if (next_done) m_ending = 0;
    m_net = (m_net && !m_done) || nf;
    if (m_done) m_ins_cnt = 0;
    else if (pop && m_ins_cnt != 65535) m_ins_cnt++;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d);
    m_af   = (mq.size() >= AF_TH);
    m_done = next_done;

    @(posedge clk_calc);
    @(negedge clk_calc);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ins_in_vld = 0; ins_in = '0; last_slice_vld = 0; net_map_finish = 0; ddr_ins_rdy = 0;
    repeat (2) @(negedge clk_calc);
    rst = 1'b0;
    model_reset();
  endtask

  int unsigned ld_before;

  initial begin
    rst = 1'b1;
    ins_in_vld = 0; ins_in = '0; last_slice_vld = 0; net_map_finish = 0; ddr_ins_rdy = 0;
    model_reset();
    @(negedge clk_calc);
    do_reset();

    // Reset mid-stream with 5 entries queued
    for (int i = 0; i < 5; i++) step(1, rnd_ins(), 0, 0, 0);
    check("pre_reset_cnt", fifo_cnt, 5);
    #2 rst = 1'b1;
    ins_in_vld = 0; last_slice_vld = 0; net_map_finish = 0; ddr_ins_rdy = 0;
    #1;
    check("rst_vld", ddr_ins_vld, 0);
    check("rst_ins", ddr_ins, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_ld", layer_done, 0);
    check("rst_nd", net_done, 0);
    check("rst_lcnt", layer_ins_cnt, 0);
    @(negedge clk_calc);
    rst = 1'b0;
    model_reset();
    idle(2, 1);

    // Latency and ordering
    for (int i = 0; i < 3; i++) step(1, rnd_ins(), 0, 0, 1);
    idle(3, 1);

    // Backpressure to full, then overflow, then drain
    for (int i = 0; i < 17; i++) step(1, rnd_ins(), 0, 0, 0);
    check("bp_full_cnt", fifo_cnt, 16);
    check("bp_ovf", ovf_err, 1);
    idle(18, 1);

    // Full with push+pop: no drop
    do_reset();
    for (int i = 0; i < 16; i++) step(1, rnd_ins(), 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, rnd_ins(), 0, 0, 1);
    check("pp_ovf", ovf_err, 0);
    check("pp_cnt", fifo_cnt, 16);
    idle(18, 1);

    // Layer completion with net finish on the last instruction
    do_reset();
    ld_before = n_ld;
    for (int i = 0; i < 8; i++) step(1, rnd_ins(), i == 7, i == 7, i[0]);
    for (int i = 0; i < 30; i++) step(0, '0, 0, 0, i[0]);
    check("layer_pulses", n_ld - ld_before, 1);

    // Empty layer
    step(0, '0, 1, 0, 1);
    idle(4, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), rnd_ins(), $urandom_range(0, 39) == 0,
           $urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0);
    idle(30, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
